// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the L1 cache controller.
package cache_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS_RD = 2'd1,
        BUS_WR = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Index bits select the line; everything above them is the tag.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return ADDR_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: valid/tag/data per one-byte line, one lookup
// port, one update port and one snoop-invalidate port.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_addr,
    input  logic [DATA_W-1:0] update_data,
    input  logic              snoop_en,
    input  logic [ADDR_W-1:0] snoop_addr
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES];

    logic [IDX_W-1:0] lk_idx, up_idx, sn_idx;
    logic [TAG_W-1:0] lk_tag, up_tag, sn_tag;
    logic             snoop_kill;

    assign lk_idx = lookup_addr[IDX_W-1:0];
    assign lk_tag = lookup_addr[ADDR_W-1:IDX_W];
    assign up_idx = update_addr[IDX_W-1:0];
    assign up_tag = update_addr[ADDR_W-1:IDX_W];
    assign sn_idx = snoop_addr[IDX_W-1:0];
    assign sn_tag = snoop_addr[ADDR_W-1:IDX_W];

    // A same-cycle snoop kill on the looked-up line turns the lookup into a miss.
    always_comb begin
        snoop_kill  = snoop_en && valid[sn_idx] && (tags[sn_idx] == sn_tag);
        lookup_hit  = valid[lk_idx] && (tags[lk_idx] == lk_tag) &&
                      !(snoop_kill && (sn_idx == lk_idx));
        lookup_data = data[lk_idx];
    end

    // Valid bits: update is applied after the snoop clear so a fill wins, since
    // the arbitrator ordered our bus transaction after the other port's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (snoop_kill) valid[sn_idx] <= 1'b0;
            if (update_en)  valid[up_idx] <= 1'b1;
        end
    end

    // Tag and data storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (update_en) begin
            tags[up_idx] <= up_tag;
            data[up_idx] <= update_data;
        end
    end

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped write-through L1 cache controller for one arbitrator port.
module l1_cache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              bus_access,
    output logic              cache_write,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              finish,
    input  logic              snoop_flag,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t            state, state_next;
    logic              lookup_hit;
    logic [DATA_W-1:0] lookup_data;
    logic              update_en;
    logic [ADDR_W-1:0] update_addr;
    logic [DATA_W-1:0] update_data;
    logic              take_hit, take_miss, take_write;

    cache_line_array #(.LINES(LINES)) u_lines (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (cpu_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .update_en   (update_en),
        .update_addr (update_addr),
        .update_data (update_data),
        .snoop_en    (snoop_flag),
        .snoop_addr  (snoop_addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and per-cycle strobes; finish outside the bus states is ignored.
    always_comb begin
        state_next  = state;
        take_hit    = 1'b0;
        take_miss   = 1'b0;
        take_write  = 1'b0;
        update_en   = 1'b0;
        update_addr = read_address;
        update_data = read_data;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        take_write = 1'b1;
                        state_next = BUS_WR;
                    end else if (lookup_hit) begin
                        take_hit   = 1'b1;
                        state_next = RESP;
                    end else begin
                        take_miss  = 1'b1;
                        state_next = BUS_RD;
                    end
                end
            end
            BUS_RD: begin
                if (finish) begin
                    update_en  = 1'b1;
                    state_next = RESP;
                end
            end
            BUS_WR: begin
                if (finish) begin
                    update_en   = 1'b1;
                    update_addr = write_address;
                    update_data = write_data;
                    state_next  = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs, derived from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_access    <= 1'b0;
            cache_write   <= 1'b0;
            cpu_ready     <= 1'b0;
            cpu_rdata     <= '0;
            read_address  <= '0;
            write_address <= '0;
            write_data    <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            bus_access  <= (state_next == BUS_RD) || (state_next == BUS_WR);
            cache_write <= (state_next == BUS_WR);
            cpu_ready   <= (state_next == RESP);
            if (take_hit) begin
                cpu_rdata <= lookup_data;
                hit_cnt   <= hit_cnt + 1'b1;
            end
            if (take_miss) begin
                read_address <= cpu_addr;
                miss_cnt     <= miss_cnt + 1'b1;
            end
            if (take_write) begin
                write_address <= cpu_addr;
                write_data    <= cpu_wdata;
            end
            if ((state == BUS_RD) && finish) cpu_rdata <= read_data;
        end
    end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench: the driver plays CPU, arbitrator and the other port's
// snoops; a monitor compares bus requests and CPU responses against queues.
module tb_l1_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_ready, bus_access, cache_write;
    logic [7:0] read_address, write_address, write_data, read_data;
    logic       finish, snoop_flag;
    logic [7:0] snoop_addr;
    logic [15:0] hit_cnt, miss_cnt;

    l1_cache_ctrl #(.LINES(16), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ready     (cpu_ready),
        .bus_access    (bus_access),
        .cache_write   (cache_write),
        .read_address  (read_address),
        .write_address (write_address),
        .write_data    (write_data),
        .read_data     (read_data),
        .finish        (finish),
        .snoop_flag    (snoop_flag),
        .snoop_addr    (snoop_addr),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_write;
        logic [7:0] data;
        int         hc;
        int         mc;
    } resp_t;

    typedef struct {
        bit         is_write;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    // Reference model: backing memory and the set of byte addresses that the
    // cache currently holds (at most one per address modulo 16).
    logic [7:0] mem [256];
    bit         cached [256];
    int         exp_hit = 0;
    int         exp_miss = 0;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    function automatic logic [7:0] pool_addr();
        logic [7:0] a;
        a = 8'(($urandom_range(0, 3) * 16) + $urandom_range(0, 3));
        return a;
    endfunction

    function automatic void fill(input logic [7:0] a);
        for (int i = 0; i < 256; i++)
            if ((i % 16) == (int'(a) % 16)) cached[i] = 1'b0;
        cached[a] = 1'b1;
    endfunction

    // The other port writes memory at snoop_addr during this cycle.
    task automatic drive_snoop(input logic [7:0] s);
        snoop_flag = 1'b1;
        snoop_addr = s;
        mem[s]     = 8'($urandom);
        cached[s]  = 1'b0;
    endtask

    task automatic bg_snoop();
        snoop_flag = 1'b0;
        if ($urandom_range(0, 7) == 0) drive_snoop(pool_addr());
    endtask

    task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] wd,
                         input bit sn_iss, input logic [7:0] sa_iss,
                         input bit sn_fin, input logic [7:0] sa_fin);
        bit hit;
        int w;
        @(negedge clk);
        snoop_flag = 1'b0;
        if (sn_iss) drive_snoop(sa_iss);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        hit = !we && cached[a];
        if (we) begin
            bus_q.push_back('{1'b1, a, wd});
        end else if (hit) begin
            exp_hit++;
            resp_q.push_back('{1'b0, mem[a], exp_hit, exp_miss});
        end else begin
            exp_miss++;
            bus_q.push_back('{1'b0, a, 8'h00});
        end
        @(negedge clk);
        snoop_flag = 1'b0;
        if (!hit) begin
            w = 0;
            while (!bus_access && w < 8) begin
                @(negedge clk);
                w++;
            end
            if (!bus_access) begin
                check("bus_access_timeout", {31'd0, bus_access}, 32'd1);
                cpu_req = 1'b0;
                return;
            end
            repeat ($urandom_range(0, 3)) begin
                bg_snoop();
                @(negedge clk);
            end
            snoop_flag = 1'b0;
            if (sn_fin) drive_snoop(sa_fin);
            if (we) mem[a] = wd;
            finish    = 1'b1;
            read_data = we ? 8'($urandom) : mem[a];
            fill(a);
            resp_q.push_back('{we, mem[a], exp_hit, exp_miss});
            @(negedge clk);
            finish     = 1'b0;
            snoop_flag = 1'b0;
            read_data  = 8'($urandom);
        end
        w = 0;
        while (!cpu_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!cpu_ready) check("cpu_ready_timeout", {31'd0, cpu_ready}, 32'd1);
        cpu_req = 1'b0;
    endtask

    task automatic idle_cycle(input bit sn, input logic [7:0] sa);
        @(negedge clk);
        cpu_req    = 1'b0;
        snoop_flag = 1'b0;
        if (sn) drive_snoop(sa);
        @(negedge clk);
        snoop_flag = 1'b0;
    endtask

    // Monitor: compares each bus request as it rises and each CPU response.
    bit bus_prev = 1'b0;
    always @(negedge clk) begin
        if (bus_access && !bus_prev) begin
            if (bus_q.size() == 0) begin
                fail_event("unexpected_bus_access");
            end else begin
                bus_t b;
                b = bus_q.pop_front();
                check("cache_write", {31'd0, cache_write}, {31'd0, b.is_write});
                if (b.is_write) begin
                    check("write_address", {24'd0, write_address}, {24'd0, b.addr});
                    check("write_data", {24'd0, write_data}, {24'd0, b.data});
                end else begin
                    check("read_address", {24'd0, read_address}, {24'd0, b.addr});
                end
            end
        end
        bus_prev = bus_access;
        if (cpu_ready) begin
            if (resp_q.size() == 0) begin
                fail_event("unexpected_cpu_ready");
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                if (!r.is_write) check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, r.data});
                check("hit_cnt", {16'd0, hit_cnt}, 32'(r.hc));
                check("miss_cnt", {16'd0, miss_cnt}, 32'(r.mc));
                check("bus_access_in_resp", {31'd0, bus_access}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'($urandom);
            cached[i] = 1'b0;
        end
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        read_data = '0; finish = 1'b0; snoop_flag = 1'b0; snoop_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus_access", {31'd0, bus_access}, 32'd0);
        check("rst_cache_write", {31'd0, cache_write}, 32'd0);
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("rst_read_address", {24'd0, read_address}, 32'd0);
        check("rst_write_address", {24'd0, write_address}, 32'd0);
        check("rst_write_data", {24'd0, write_data}, 32'd0);
        check("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        check("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);

        // Directed scenarios.
        mem[8'h35] = 8'hA7;
        issue(1'b0, 8'h35, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);   // miss
        issue(1'b0, 8'h35, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);   // hit
        issue(1'b1, 8'h12, 8'h5C, 1'b0, 8'h00, 1'b0, 8'h00);   // write
        issue(1'b0, 8'h12, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);   // hit 0x5C
        idle_cycle(1'b1, 8'h35);
        issue(1'b0, 8'h35, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);   // miss after snoop
        idle_cycle(1'b1, 8'h45);
        issue(1'b0, 8'h35, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);   // still hit
        issue(1'b0, 8'h35, 8'h00, 1'b1, 8'h35, 1'b0, 8'h00);   // snoop beats lookup
        issue(1'b1, 8'h12, 8'h9E, 1'b0, 8'h00, 1'b1, 8'h12);   // fill beats snoop
        issue(1'b0, 8'h12, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);   // hit 0x9E

        // Reset while in BUS_RD.
        @(negedge clk);
        drive_snoop(8'h35);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h35;
        bus_q.push_back('{1'b0, 8'h35, 8'h00});
        @(negedge clk);
        snoop_flag = 1'b0;
        check("rr_bus_access_before", {31'd0, bus_access}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b0;
        check("rr_bus_access_after", {31'd0, bus_access}, 32'd0);
        for (int i = 0; i < 256; i++) cached[i] = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        @(negedge clk);
        finish = 1'b1;
        read_data = mem[8'h35];
        @(negedge clk);
        finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rr_no_cpu_ready", {31'd0, cpu_ready}, 32'd0);
            @(negedge clk);
        end
        issue(1'b0, 8'h35, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);   // miss after reset

        // Randomized traffic over a small address pool to create hits/conflicts.
        for (int n = 0; n < 200; n++) begin
            bit we;
            bit si;
            bit sf;
            we = ($urandom_range(0, 3) == 0);
            si = ($urandom_range(0, 5) == 0);
            sf = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 1) == 1, pool_addr());
            issue(we, pool_addr(), 8'($urandom), si, pool_addr(), sf, pool_addr());
        end

        repeat (4) @(negedge clk);
        check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
        check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l1_cache_ctrl.md
# l1_cache_ctrl

Direct-mapped, write-through L1 cache controller for one processor port, sitting directly upstream of the two-port bus arbitrator (one instance per port). Services CPU byte reads/writes from a local line array. Forwards misses and all writes to the arbitrator with a level bus-request/finish-pulse handshake. Invalidates lines named by the arbitrator's snoop flag/address so the two caches stay coherent.

## Interface
- LINES, 16, number of one-byte lines; power of two; index = addr[log2(LINES)-1:0], tag = remaining upper bits of the 8-bit address
- CNT_W, 16, width of hit/miss statistics counters
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  request valid; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  8  byte address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid when cpu_ready=1 for a read
- cpu_ready  out  1  one-cycle completion pulse
- bus_access  out  1  bus request to arbitrator; level
- cache_write  out  1  1 = bus write, 0 = bus read; valid while bus_access=1
- read_address  out  8  bus read address
- write_address  out  8  bus write address
- write_data  out  8  bus write data
- read_data  in  8  data returned by arbitrator; valid in the finish cycle
- finish  in  1  one-cycle completion pulse from arbitrator
- snoop_flag  in  1  other port wrote memory this cycle
- snoop_addr  in  8  address written by the other port
- hit_cnt  out  CNT_W  read hits, wrapping
- miss_cnt  out  CNT_W  read misses, wrapping

## Operation
- FSM states: IDLE, BUS_RD, BUS_WR, RESP.
- IDLE, cpu_req=1, cpu_we=0, line valid and tag match → hit: load cpu_rdata from line, hit_cnt+1, → RESP.
- IDLE, read miss → capture addr, miss_cnt+1, → BUS_RD.
- IDLE, cpu_we=1 → capture addr/data, → BUS_WR (write-through, always uses bus).
- BUS_RD: bus_access=1, cache_write=0, read_address=captured addr. On finish: line[idx] ← {valid=1, tag, read_data}, cpu_rdata ← read_data, → RESP.
- BUS_WR: bus_access=1, cache_write=1, write_address/write_data = captured. On finish: line[idx] ← {valid=1, tag, data} (write-allocate; one-byte lines need no fill), → RESP.
- RESP: cpu_ready=1 for exactly one cycle, → IDLE. New cpu_req not sampled in RESP.
- finish while in IDLE or RESP is ignored.
- Snoop: any cycle, snoop_flag=1 and line[idx(snoop_addr)] valid with matching tag → valid cleared.
- Snoop vs hit lookup, same cycle, same line: snoop wins; lookup sees invalid → miss.
- Snoop vs fill/write-update, same cycle, same line: fill/update wins (our bus transaction was serialised after the other write by the arbitrator).
- Counters wrap at 2^CNT_W; writes do not count.

## Timing
- Reset (rst=1 at edge): all valid bits 0, state IDLE, bus_access, cache_write, cpu_ready 0; cpu_rdata, read_address, write_address, write_data 0; counters 0. Line data/tags not cleared.
- Reset mid-transaction: bus_access drops the cycle after the rst edge; late finish ignored; CPU request lost (no cpu_ready).
- Read hit: cpu_req sampled at edge N → cpu_ready high in cycle N+1.
- Miss/write: bus_access rises at edge N; finish sampled at edge M → bus_access low and cpu_ready high from edge M, for one cycle. Total latency = arbitrator latency + 1.
- All outputs registered; bus_access never high in RESP, so arbitrator sees a gap of ≥1 cycle between back-to-back requests.
- Snoop invalidate takes effect at the edge sampling snoop_flag.

## Structure
- Package cache_pkg: ADDR_W=8, DATA_W=8, state enum (IDLE, BUS_RD, BUS_WR, RESP), index/tag width functions of LINES.
- Sub-module cache_line_array: valid/tag/data storage, one lookup port, one update port, one snoop-invalidate port with the priority rules above. Controller FSM and counters in l1_cache_ctrl.

## Test plan
- Reset, then read 0x35 with memory[0x35]=0xA7, finish 3 cycles later → bus_access read of 0x35, cpu_rdata=0xA7 with cpu_ready; repeat read → hit, cpu_ready next cycle, no bus_access, hit_cnt=1, miss_cnt=1.
- Write 0x12←0x5C → bus_access with cache_write=1, write_address=0x12, write_data=0x5C; after finish, read 0x12 hits with 0x5C.
- Fill 0x35, then snoop_flag=1 snoop_addr=0x35 → next read 0x35 misses; snoop_addr=0x45 (same index, other tag) → line stays valid.
- Snoop on 0x35 in same cycle as read request to cached 0x35 → treated as miss, bus read issued.
- Snoop 0x12 in same cycle as finish of write to 0x12 → line valid with new data afterwards.
- Assert rst while in BUS_RD → bus_access 0 next cycle; later finish pulse produces no cpu_ready; all valid bits clear (read of 0x35 misses).
